// File: rtl/note_recorder_pkg.sv
// Shared constants and types for the note recorder: state encoding, entry layout, defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package note_recorder_pkg;

    localparam int DEPTH_DEF    = 16;
    localparam int TICK_DIV_DEF = 400000;   // 10 ms at 40 MHz

    localparam int KEY_W   = 4;
    localparam int DUR_W   = 11;
    localparam int COUNT_W = 5;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_ARM    = 2'd1;
    localparam logic [STATE_W-1:0] ST_RECORD = 2'd2;
    localparam logic [STATE_W-1:0] ST_PLAY   = 2'd3;

    localparam logic [DUR_W-1:0] DUR_MAX = 11'd2047;

    // 16-bit stored segment: {is_note, key, dur}
    typedef struct packed {
        logic             is_note;
        logic [KEY_W-1:0] key;
        logic [DUR_W-1:0] dur;
    } entry_t;

endpackage

// File: rtl/note_recorder_tick_gen.sv
// Duration prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
// Latency: first tick on the TICK_DIV-th enabled cycle after a clear.
// Backpressure: none; clr has priority over counting.
// Ports: clk, rst (sync, active-high), en (count enable), clr (sync clear), tick (pulse out).
module note_recorder_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Records keypad note/rest segments with tick durations and plays them back to tone_setting.
// Latency: passthrough 1 cycle (registered key/pressed); playback starts the cycle after play_start.
// Backpressure: none; recording stops when the buffer is full, extra presses are dropped.
// Ports: clk, rst (sync, active-high); key/pressed from keypad; rec_en level, play_start pulse;
//        key_out/pressed_out to tone_setting; state, count, full status.
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key,
    input  logic               pressed,
    input  logic               rec_en,
    input  logic               play_start,
    output logic [KEY_W-1:0]   key_out,
    output logic               pressed_out,
    output logic [STATE_W-1:0] state,
    output logic [COUNT_W-1:0] count,
    output logic               full
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t mem [DEPTH];

    logic [KEY_W-1:0]   key_r;
    logic               pressed_r;
    logic               rec_q;

    // open recording segment
    logic               seg_note;
    logic [KEY_W-1:0]   seg_key;
    logic [DUR_W-1:0]   seg_dur;

    // playback: current entry plus a prefetched next entry
    logic               play_note;
    logic [KEY_W-1:0]   play_key;
    logic [DUR_W-1:0]   play_left;
    logic [COUNT_W-1:0] play_idx;
    entry_t             next_entry;
    logic               mute;

    logic               tick, tick_en, tick_clr;
    logic               rec_rise, seg_end, close_seg, keep, full_after;
    logic               play_step, play_last;
    logic [DUR_W-1:0]   dur_eff;
    logic [COUNT_W-1:0] idx_plus1, idx_plus2;
    entry_t             closing_entry;

    assign rec_rise = rec_en && !rec_q;

    // A tick landing on the closing cycle still belongs to the closing segment.
    assign dur_eff = (tick && seg_dur != DUR_MAX) ? seg_dur + DUR_W'(1) : seg_dur;

    assign seg_end    = (pressed_r != seg_note) || (pressed_r && key_r != seg_key) ||
                        (seg_dur == DUR_MAX);
    assign close_seg  = (state == ST_RECORD) && (seg_end || !rec_en);
    assign keep       = (dur_eff != '0);
    assign full_after = keep && (count + COUNT_W'(1) == COUNT_W'(DEPTH));

    assign closing_entry = '{is_note: seg_note, key: seg_key, dur: dur_eff};

    assign idx_plus1 = play_idx + COUNT_W'(1);
    assign idx_plus2 = play_idx + COUNT_W'(2);
    assign play_step = tick && (play_left <= DUR_W'(1));
    assign play_last = (idx_plus1 == count);

    // Prescaler idles at zero outside RECORD/PLAY so each segment or entry starts on a fresh period.
    assign tick_en  = (state == ST_RECORD) || (state == ST_PLAY);
    assign tick_clr = (state == ST_IDLE) || (state == ST_ARM) || close_seg ||
                      ((state == ST_PLAY) && (play_start || play_step));

    note_recorder_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (close_seg && keep) begin
            mem[count[ADDR_W-1:0]] <= closing_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_r      <= '0;
            pressed_r  <= 1'b0;
            rec_q      <= 1'b0;
            state      <= ST_IDLE;
            count      <= '0;
            seg_note   <= 1'b0;
            seg_key    <= '0;
            seg_dur    <= '0;
            play_note  <= 1'b0;
            play_key   <= '0;
            play_left  <= '0;
            play_idx   <= '0;
            next_entry <= '0;
            mute       <= 1'b0;
        end else begin
            key_r     <= key;
            pressed_r <= pressed;
            rec_q     <= rec_en;
            mute      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rec_rise) begin
                        state <= ST_ARM;
                        count <= '0;
                    end else if (play_start && count != '0) begin
                        state      <= ST_PLAY;
                        play_idx   <= '0;
                        play_note  <= mem[ADDR_W'(0)].is_note;
                        play_key   <= mem[ADDR_W'(0)].key;
                        play_left  <= mem[ADDR_W'(0)].dur;
                        next_entry <= mem[ADDR_W'(1)];
                    end
                end
                ST_ARM: begin
                    if (!rec_en) begin
                        state <= ST_IDLE;
                    end else if (pressed_r) begin
                        state    <= ST_RECORD;
                        seg_note <= 1'b1;
                        seg_key  <= key_r;
                        seg_dur  <= '0;
                    end
                end
                ST_RECORD: begin
                    seg_dur <= dur_eff;
                    if (close_seg) begin
                        if (keep) begin
                            count <= count + COUNT_W'(1);
                        end
                        seg_note <= pressed_r;
                        seg_key  <= key_r;
                        seg_dur  <= '0;
                        if (!rec_en || full_after) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_PLAY: begin
                    if (rec_rise) begin
                        state <= ST_ARM;
                        count <= '0;
                    end else if (play_start) begin
                        play_idx   <= '0;
                        play_note  <= mem[ADDR_W'(0)].is_note;
                        play_key   <= mem[ADDR_W'(0)].key;
                        play_left  <= mem[ADDR_W'(0)].dur;
                        next_entry <= mem[ADDR_W'(1)];
                    end else if (tick) begin
                        play_left <= play_left - DUR_W'(1);
                        if (play_step) begin
                            if (play_last) begin
                                state <= ST_IDLE;
                                mute  <= 1'b1;
                            end else begin
                                play_idx   <= idx_plus1;
                                play_note  <= next_entry.is_note;
                                play_key   <= next_entry.key;
                                play_left  <= next_entry.dur;
                                next_entry <= mem[idx_plus2[ADDR_W-1:0]];
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Playback drives the tone path; one muted cycle separates the end of playback from passthrough.
    always_comb begin
        key_out     = key_r;
        pressed_out = pressed_r;
        if (state == ST_PLAY) begin
            key_out     = play_key;
            pressed_out = play_note;
        end else if (mute) begin
            pressed_out = 1'b0;
        end
    end

    assign full = (count == COUNT_W'(DEPTH));

endmodule

// File: tb/tb_note_recorder.sv
module tb_note_recorder;
    import note_recorder_pkg::*;

    localparam int TD = 4;
    localparam int DP = 16;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic       pressed;
    logic       rec_en;
    logic       play_start;
    logic [3:0] key_out;
    logic       pressed_out;
    logic [1:0] state;
    logic [4:0] count;
    logic       full;

    note_recorder #(.DEPTH(DP), .TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .pressed     (pressed),
        .rec_en      (rec_en),
        .play_start  (play_start),
        .key_out     (key_out),
        .pressed_out (pressed_out),
        .state       (state),
        .count       (count),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit         rst;
        bit         rec;
        bit         play;
        bit         prs;
        logic [3:0] k;
        logic [1:0] e_state;
        logic [4:0] e_count;
        bit         e_full;
        bit         e_po;
        logic [3:0] e_ko;
    } vec_t;

    typedef struct {
        bit         lvl;
        logic [3:0] k;
        int         len;
    } run_t;

    typedef struct {
        bit         note;
        logic [3:0] k;
        int         dur;
    } ent_t;

    vec_t vt[13];
    run_t runs[$];
    ent_t exp_ent[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // advance one clock; returns at the falling edge where outputs are stable
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(bit r, bit rc, bit pl, bit pr, logic [3:0] k,
                                logic [1:0] es, logic [4:0] ec, bit ef, bit ep, logic [3:0] ek);
        vec_t v;
        v.rst = r; v.rec = rc; v.play = pl; v.prs = pr; v.k = k;
        v.e_state = es; v.e_count = ec; v.e_full = ef; v.e_po = ep; v.e_ko = ek;
        return v;
    endfunction

    // Reference: each run of constant (pressed, key-while-pressed) is one segment whose
    // duration is the number of whole tick periods it lasted; zero-length segments vanish
    // and the buffer keeps only the first DP survivors.
    function automatic void build_model();
        exp_ent.delete();
        foreach (runs[i]) begin
            int d;
            d = runs[i].len / TD;
            if (d > 2047) d = 2047;
            if (d > 0 && exp_ent.size() < DP) begin
                ent_t e;
                e.note = runs[i].lvl;
                e.k    = runs[i].k;
                e.dur  = d;
                exp_ent.push_back(e);
            end
        end
    endfunction

    task automatic drive_run(input run_t r);
        pressed = r.lvl;
        if (r.lvl) key = r.k;
        repeat (r.len) step();
    endtask

    task automatic rec_end();
        pressed = 1'b0;
        step();
        rec_en = 1'b0;
        step();
        build_model();
    endtask

    task automatic record_runs();
        rec_en = 1'b1;
        foreach (runs[i]) drive_run(runs[i]);
        rec_end();
    endtask

    // Pulses play_start and checks every playback cycle against the model.
    // stop_after >= 0 returns early (inside PLAY) after that many checked cycles.
    task automatic play_and_check(input string tag, input int stop_after);
        int total;
        total = 0;
        foreach (exp_ent[e]) total += exp_ent[e].dur * TD;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        for (int c = 0; c < total; c++) begin
            int acc;
            int idx;
            if (stop_after >= 0 && c == stop_after) return;
            acc = 0;
            idx = 0;
            foreach (exp_ent[e]) begin
                if (c >= acc) idx = e;
                acc += exp_ent[e].dur * TD;
            end
            chk({tag, "_play_state"}, state, ST_PLAY);
            chk({tag, "_play_pressed"}, pressed_out, exp_ent[idx].note);
            if (exp_ent[idx].note) chk({tag, "_play_key"}, key_out, exp_ent[idx].k);
            step();
        end
        chk({tag, "_end_state"}, state, ST_IDLE);
        chk({tag, "_end_pressed"}, pressed_out, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; key = '0; pressed = 1'b0; rec_en = 1'b0; play_start = 1'b0;

        //       rst rec ply prs key | state    cnt full po ko
        vt[0]  = mk(1, 0, 0, 0, 4'd0, ST_IDLE,   0, 0, 0, 4'd0);
        vt[1]  = mk(0, 0, 0, 1, 4'd3, ST_IDLE,   0, 0, 1, 4'd3);
        vt[2]  = mk(0, 0, 0, 0, 4'd7, ST_IDLE,   0, 0, 0, 4'd7);
        vt[3]  = mk(0, 0, 1, 0, 4'd7, ST_IDLE,   0, 0, 0, 4'd7);  // play with empty buffer
        vt[4]  = mk(0, 1, 1, 0, 4'd7, ST_ARM,    0, 0, 0, 4'd7);  // record beats play
        vt[5]  = mk(0, 0, 0, 0, 4'd7, ST_IDLE,   0, 0, 0, 4'd7);  // rec_en drop in ARM
        vt[6]  = mk(0, 1, 0, 0, 4'd7, ST_ARM,    0, 0, 0, 4'd7);
        vt[7]  = mk(0, 1, 0, 0, 4'd2, ST_ARM,    0, 0, 0, 4'd2);
        vt[8]  = mk(0, 0, 0, 0, 4'd2, ST_IDLE,   0, 0, 0, 4'd2);
        vt[9]  = mk(0, 1, 0, 0, 4'd2, ST_ARM,    0, 0, 0, 4'd2);
        vt[10] = mk(0, 1, 0, 1, 4'd4, ST_ARM,    0, 0, 1, 4'd4);
        vt[11] = mk(0, 1, 0, 1, 4'd4, ST_RECORD, 0, 0, 1, 4'd4);
        vt[12] = mk(0, 0, 0, 1, 4'd4, ST_IDLE,   0, 0, 1, 4'd4);  // zero-length segment dropped

        for (int i = 0; i < 13; i++) begin
            rst = vt[i].rst; rec_en = vt[i].rec; play_start = vt[i].play;
            pressed = vt[i].prs; key = vt[i].k;
            step();
            chk($sformatf("vec%0d_state", i), state, vt[i].e_state);
            chk($sformatf("vec%0d_count", i), count, vt[i].e_count);
            chk($sformatf("vec%0d_full", i), full, vt[i].e_full);
            chk($sformatf("vec%0d_pressed", i), pressed_out, vt[i].e_po);
            chk($sformatf("vec%0d_key", i), key_out, vt[i].e_ko);
        end
        rst = 1'b0; rec_en = 1'b0; play_start = 1'b0; pressed = 1'b0; key = '0;
        step();

        // key 5 for 12, rest 8, key 9 for 8
        runs.delete();
        runs.push_back('{1'b1, 4'd5, 12});
        runs.push_back('{1'b0, 4'd0, 8});
        runs.push_back('{1'b1, 4'd9, 8});
        record_runs();
        chk("basic_count", count, 5'd3);
        chk("basic_state", state, ST_IDLE);
        chk("basic_full", full, 1'b0);
        play_and_check("basic", -1);
        pressed = 1'b1;
        step();
        chk("passthrough_resume", pressed_out, 1'b1);
        pressed = 1'b0;
        step();

        // restart mid-playback
        play_and_check("pre_restart", 5);
        play_and_check("restart", -1);

        // reset during playback
        play_and_check("pre_rst", 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_play_state", state, ST_IDLE);
        chk("rst_play_pressed", pressed_out, 1'b0);
        chk("rst_play_count", count, 5'd0);
        chk("rst_play_full", full, 1'b0);

        // glitch filter: sub-tick presses and rests leave count unchanged
        runs.delete();
        runs.push_back('{1'b1, 4'd2, 8});
        runs.push_back('{1'b0, 4'd0, 2});
        runs.push_back('{1'b1, 4'd2, 3});
        runs.push_back('{1'b0, 4'd0, 2});
        rec_en = 1'b1;
        foreach (runs[i]) drive_run(runs[i]);
        chk("glitch_count", count, 5'd1);
        chk("glitch_state", state, ST_RECORD);
        runs.push_back('{1'b1, 4'd2, 8});
        drive_run(runs[4]);
        rec_end();
        chk("glitch_final_count", count, 5'd2);
        play_and_check("glitch", -1);

        // randomized recordings against the run-length model
        for (int it = 0; it < 6; it++) begin
            int nr;
            bit prev_lvl;
            logic [3:0] prev_k;
            runs.delete();
            nr = $urandom_range(2, 9);
            prev_lvl = 1'b0;
            prev_k = '0;
            for (int r = 0; r < nr; r++) begin
                run_t rr;
                if (r == 0) rr.lvl = 1'b1;
                else if (!prev_lvl) rr.lvl = 1'b1;
                else rr.lvl = ($urandom_range(0, 9) < 3);
                rr.k = rr.lvl ? 4'($urandom_range(0, 15)) : prev_k;
                if (rr.lvl && prev_lvl && r > 0 && rr.k == prev_k) rr.k = prev_k + 4'd1;
                rr.len = (r == 0) ? $urandom_range(4, 14) : $urandom_range(1, 14);
                runs.push_back(rr);
                prev_lvl = rr.lvl;
                prev_k = rr.k;
            end
            if (!prev_lvl) runs.push_back('{1'b1, 4'($urandom_range(0, 15)), $urandom_range(4, 10)});
            record_runs();
            chk($sformatf("rand%0d_count", it), count, exp_ent.size());
            chk($sformatf("rand%0d_state", it), state, ST_IDLE);
            play_and_check($sformatf("rand%0d", it), -1);
        end

        // rec_en rising during playback aborts to ARM
        play_and_check("pre_abort", 3);
        rec_en = 1'b1;
        step();
        chk("abort_state", state, ST_ARM);
        chk("abort_count", count, 5'd0);
        rec_en = 1'b0;
        step();
        chk("abort_idle", state, ST_IDLE);

        // 17 alternating segments fill the buffer
        runs.delete();
        for (int r = 0; r < 17; r++) begin
            run_t rr;
            rr.lvl = (r % 2 == 0);
            rr.k = 4'(r);
            rr.len = $urandom_range(4, 8);
            runs.push_back(rr);
        end
        rec_en = 1'b1;
        foreach (runs[i]) drive_run(runs[i]);
        chk("full_state_rec_high", state, ST_IDLE);
        chk("full_count", count, 5'd16);
        chk("full_flag", full, 1'b1);
        pressed = 1'b1; key = 4'd3;
        repeat (6) step();
        chk("full_ignore_press", count, 5'd16);
        rec_end();
        chk("full_state", state, ST_IDLE);
        play_and_check("full", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
